idct_1d_stream: RTL and testbench



---
 rtl/idct_1d_stream.sv | 159 +++++++++++++++
 tb/tb_idct_1d_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/idct_1d_stream.sv
// rtl/idct_1d_stream.sv - serial 8-point 1-D inverse DCT with ping-pong input buffer
module idct_1d_stream #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 9
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    En_In,
    input  logic signed [IN_W-1:0]  Data_In,
    output logic                    En_Out,
    output logic signed [OUT_W-1:0] Data_Out
);

    // Exact accumulator: 12-bit coefficient times IN_W input, summed over 8 terms
    localparam int ACC_W   = IN_W + 15;
    localparam int SAT_MAX = (2 ** (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (OUT_W - 1));

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_emit;
    logic [2:0]              r_wr_cnt;
    logic                    r_wr_bank;
    logic                    r_rd_bank;
    logic [2:0]              r_out_cnt;
    logic signed [IN_W-1:0]  r_buf [2][8];
    logic                    w_handover;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [OUT_W-1:0] w_sat;

    // Table entry T[n][k] = round(2048*c(k)*cos((2n+1)k*pi/16)), folded onto the first quadrant
    function automatic logic signed [11:0] coef(input logic [2:0] n, input logic [2:0] k);
        logic [6:0]         p;
        logic [4:0]         m;
        logic [4:0]         idx;
        logic               neg;
        logic signed [11:0] mag;
        p   = {3'b000, n, 1'b1} * {4'b0000, k};
        m   = p[4:0];
        if (m > 5'd16) begin
            m = 5'd0 - m;
        end
        neg = (m > 5'd8);
        idx = neg ? (5'd16 - m) : m;
        case (idx)
            5'd1:    mag = 12'sd2009;
            5'd2:    mag = 12'sd1892;
            5'd3:    mag = 12'sd1703;
            5'd4:    mag = 12'sd1448;
            5'd5:    mag = 12'sd1138;
            5'd6:    mag = 12'sd784;
            5'd7:    mag = 12'sd400;
            default: mag = 12'sd0;
        endcase
        if (k == 3'd0) begin
            coef = 12'sd1448;
        end else if (neg) begin
            coef = -mag;
        end else begin
            coef = mag;
        end
    endfunction

    // A completed block is handed to the output side on the edge that writes entry 7
    assign w_handover = En_In && (r_wr_cnt == 3'd7);

    // Coefficient storage; contents need no reset
    always_ff @(posedge Clock) begin
        if (En_In) begin
            r_buf[r_wr_bank][r_wr_cnt] <= Data_In;
        end
    end

    // Write pointer and bank select
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_cnt  <= 3'd0;
            r_wr_bank <= 1'b0;
        end else if (En_In) begin
            r_wr_cnt <= r_wr_cnt + 3'd1;
            if (r_wr_cnt == 3'd7) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Output sequencer state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output sequencer next state; a hand-over on the y[7] cycle keeps streaming without a gap
    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_handover) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                w_emit = 1'b1;
                if ((r_out_cnt == 3'd7) && !w_handover) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One output sample per cycle: dot product of table row r_out_cnt with the read bank
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < 8; k++) begin
            w_acc = w_acc + ACC_W'(coef(r_out_cnt, 3'(k))) * ACC_W'(r_buf[r_rd_bank][k]);
        end
        w_shift = (w_acc + ACC_W'(2048)) >>> 12;
        if (w_shift > ACC_W'(SAT_MAX)) begin
            w_sat = OUT_W'(SAT_MAX);
        end else if (w_shift < ACC_W'(SAT_MIN)) begin
            w_sat = OUT_W'(SAT_MIN);
        end else begin
            w_sat = OUT_W'(w_shift);
        end
    end

    // Registered output and read-side pointers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            En_Out    <= 1'b0;
            Data_Out  <= '0;
            r_out_cnt <= 3'd0;
            r_rd_bank <= 1'b0;
        end else begin
            En_Out <= w_emit;
            if (w_emit) begin
                Data_Out <= w_sat;
            end
            if (w_handover) begin
                r_rd_bank <= r_wr_bank;
                r_out_cnt <= 3'd0;
            end else if (w_emit) begin
                r_out_cnt <= r_out_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_idct_1d_stream.sv
// tb/tb_idct_1d_stream.sv - randomized scoreboard bench for idct_1d_stream
module tb_idct_1d_stream;

    localparam int IN_W  = 12;
    localparam int OUT_W = 9;

    logic                    Clock;
    logic                    Reset_n;
    logic                    En_In;
    logic signed [IN_W-1:0]  Data_In;
    logic                    En_Out;
    logic signed [OUT_W-1:0] Data_Out;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;
    int   t_tab[8][8];

    idct_1d_stream #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En_In   (En_In),
        .Data_In (Data_In),
        .En_Out  (En_Out),
        .Data_Out(Data_Out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    function automatic int model(input int x[8], input int n);
        longint s;
        s = 2048;
        for (int k = 0; k < 8; k++) s = s + longint'(t_tab[n][k]) * longint'(x[k]);
        s = s >>> 12;
        if (s > 255) s = 255;
        if (s < -256) s = -256;
        return int'(s);
    endfunction

    task automatic put(input logic en, input int d);
        @(posedge Clock);
        #1;
        En_In   = en;
        Data_In = 12'(d);
    endtask

    // Drives one block; idle_pct is the chance of an idle cycle before each coefficient
    task automatic send_block(input int x[8], input int idle_pct);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            while ($urandom_range(99) < idle_pct) put(1'b0, 0);
            put(1'b1, x[k]);
        end
        for (int n = 0; n < 8; n++) begin
            e.val = model(x, n);
            e.cyc = cyc + 2 + n;
            sb.push_back(e);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (En_Out !== 1'b0 || Data_Out !== '0) begin
            errors++;
            $display("FAIL %s: En_Out=%0b Data_Out=%0d, required En_Out=0 Data_Out=0", name, En_Out, Data_Out);
        end
    endtask

    task automatic do_reset(input string name);
        #2;
        Reset_n = 1'b0;
        sb.delete();
        #1;
        check_reset_state(name);
        En_In = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic rand_block(output int x[8], input int range_sel);
        for (int k = 0; k < 8; k++) begin
            if (range_sel == 0) x[k] = int'($urandom_range(600)) - 300;
            else x[k] = int'($urandom_range(4095)) - 2048;
        end
    endtask

    // Monitor: expected samples carry the cycle they must appear in
    always @(negedge Clock) begin : mon
        exp_t e;
        logic exp_en;
        if (Reset_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
            end
            exp_en = (sb.size() > 0) && (sb[0].cyc == cyc);
            if (En_Out || exp_en) begin
                checks++;
                if (En_Out !== exp_en) begin
                    errors++;
                    $display("FAIL en_out cyc=%0d: got %0b, required %0b", cyc, En_Out, exp_en);
                end
            end
            if (exp_en) begin
                e = sb.pop_front();
                if (En_Out === 1'b1) begin
                    checks++;
                    if (int'(Data_Out) !== e.val) begin
                        errors++;
                        $display("FAIL data_out cyc=%0d: got %0d, required %0d", cyc, Data_Out, e.val);
                    end
                end
            end
        end
    end

    initial begin
        int x[8];
        int wait_cnt;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        Reset_n = 1'b0;
        En_In   = 1'b0;
        Data_In = '0;
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < 8; k++)
                t_tab[n][k] = rnd(2048.0 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0)
                                  * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0));
        repeat (3) @(posedge Clock);
        #1;
        check_reset_state("reset_state");
        Reset_n = 1'b1;

        // Directed: DC, negative DC, single AC, both saturation limits
        x = '{256, 0, 0, 0, 0, 0, 0, 0};     send_block(x, 0);
        x = '{-256, 0, 0, 0, 0, 0, 0, 0};    send_block(x, 0);
        x = '{0, 256, 0, 0, 0, 0, 0, 0};     send_block(x, 0);
        x = '{2047, 0, 0, 0, 0, 0, 0, 0};    send_block(x, 0);
        x = '{-2048, 0, 0, 0, 0, 0, 0, 0};   send_block(x, 0);
        put(1'b0, 0);
        repeat (12) put(1'b0, 0);

        // Back-to-back random blocks
        for (int b = 0; b < 4; b++) begin
            rand_block(x, b % 2);
            send_block(x, 0);
        end
        repeat (12) put(1'b0, 0);

        // Gapped input at roughly 30% duty
        for (int b = 0; b < 6; b++) begin
            rand_block(x, b % 2);
            send_block(x, 70);
        end
        repeat (12) put(1'b0, 0);

        // Reset after 5 inputs, then a fresh block
        for (int k = 0; k < 5; k++) put(1'b1, int'($urandom_range(600)) - 300);
        do_reset("reset_mid_block");
        rand_block(x, 0);
        send_block(x, 0);
        put(1'b0, 0);

        // Reset during an output burst, then a fresh block
        rand_block(x, 0);
        x[0] = 700;
        send_block(x, 0);
        put(1'b0, 0);
        repeat (3) put(1'b0, 0);
        do_reset("reset_mid_output");
        rand_block(x, 1);
        send_block(x, 20);
        put(1'b0, 0);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 50) begin
            @(posedge Clock);
            wait_cnt++;
        end
        @(posedge Clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d samples never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
